// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes and handshake FSM states for the multi-cycle ALU
package alu_pkg;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_MUL  = 3'b010;
   localparam logic [2:0] OP_DIV  = 3'b011;
   localparam logic [2:0] OP_MOD  = 3'b100;
   localparam logic [2:0] OP_SHL  = 3'b101;
   localparam logic [2:0] OP_SHR  = 3'b110;
   localparam logic [2:0] OP_RSVD = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - operand/result handshake bundle between operand stage and writeback
interface alu_seq_if #(
   parameter int WIDTH = 8
);
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic [2:0]         sel;
   logic               out_valid;
   logic               out_ready;
   logic [2*WIDTH-1:0] y;
   logic               err;

   modport master (
      output in_valid, a, b, sel, out_ready,
      input  in_ready, out_valid, y, err
   );

   modport slave (
      input  in_valid, a, b, sel, out_ready,
      output in_ready, out_valid, y, err
   );
endinterface

// File: rtl/alu_muldiv_iter.sv
// rtl/alu_muldiv_iter.sv - iterative shift-add multiplier and restoring divider, one bit per cycle
module alu_muldiv_iter #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               is_mul,
   output logic               done,
   output logic [2*WIDTH-1:0] prod,
   output logic [WIDTH-1:0]   quot,
   output logic [WIDTH-1:0]   rem
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   // p holds {hi, lo}: product accumulator for MUL, {remainder, quotient} for DIV/MOD
   logic [2*WIDTH-1:0] p;
   logic [2*WIDTH-1:0] p_nxt;
   logic [WIDTH-1:0]   opd;
   logic [WIDTH-1:0]   addend;
   logic [WIDTH:0]     add_s;
   logic [WIDTH:0]     trial;
   logic               mul_r;
   logic               busy;
   logic [CW-1:0]      cnt;

   always_comb begin
      addend = p[0] ? opd : {WIDTH{1'b0}};
      add_s  = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, addend};
      trial  = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]} - {1'b0, opd};
      if (mul_r)
         p_nxt = {add_s, p[WIDTH-1:1]};
      else if (!trial[WIDTH])
         p_nxt = {trial[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
      else
         p_nxt = {p[2*WIDTH-2:0], 1'b0};
   end

   // Results are taken from p_nxt so the final iteration and the DONE entry share one edge
   assign done = busy && (cnt == LAST);
   assign prod = p_nxt;
   assign quot = p_nxt[WIDTH-1:0];
   assign rem  = p_nxt[2*WIDTH-1:WIDTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p     <= '0;
         opd   <= '0;
         mul_r <= 1'b0;
         busy  <= 1'b0;
         cnt   <= '0;
      end else if (start) begin
         p     <= {{WIDTH{1'b0}}, (is_mul ? b : a)};
         opd   <= is_mul ? a : b;
         mul_r <= is_mul;
         busy  <= 1'b1;
         cnt   <= '0;
      end else if (busy) begin
         p <= p_nxt;
         if (cnt == LAST) begin
            busy <= 1'b0;
            cnt  <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle ALU: handshake FSM, single-cycle ops and result register
module alu_seq #(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic      clk,
   input  logic      rst_n,
   alu_seq_if.slave  bus
);
   import alu_pkg::*;

   state_t             state;
   state_t             state_n;
   logic               accept;
   logic               long_op;
   logic               div0;
   logic               start;
   logic [2:0]         sel_r;
   logic [WIDTH:0]     sum_w;
   logic [WIDTH:0]     diff_w;
   logic [WIDTH-1:0]   shl_w;
   logic [WIDTH-1:0]   shr_w;
   logic [2*WIDTH-1:0] fast_y;
   logic               fast_err;
   logic [2*WIDTH-1:0] slow_y;
   logic               eng_done;
   logic [2*WIDTH-1:0] eng_prod;
   logic [WIDTH-1:0]   eng_quot;
   logic [WIDTH-1:0]   eng_rem;
   logic [2*WIDTH-1:0] y_r;
   logic               err_r;

   assign bus.in_ready  = rst_n && (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.y         = y_r;
   assign bus.err       = err_r;

   assign accept  = bus.in_valid && bus.in_ready;
   assign long_op = (bus.sel == OP_MUL) || (bus.sel == OP_DIV) || (bus.sel == OP_MOD);
   assign div0    = ((bus.sel == OP_DIV) || (bus.sel == OP_MOD)) && (bus.b == '0);

   assign sum_w  = {1'b0, bus.a} + {1'b0, bus.b};
   assign diff_w = {1'b0, bus.a} - {1'b0, bus.b};
   assign shl_w  = bus.a << bus.b[SHW-1:0];
   assign shr_w  = bus.a >> bus.b[SHW-1:0];

   // Divide-by-zero is resolved here so it completes with single-cycle latency
   always_comb begin
      fast_y   = '0;
      fast_err = 1'b0;
      case (bus.sel)
         OP_ADD:  fast_y = {{(WIDTH-1){1'b0}}, sum_w};
         OP_SUB:  fast_y = {{(WIDTH-1){1'b0}}, diff_w};
         OP_DIV:  begin fast_y = {{WIDTH{1'b0}}, {WIDTH{1'b1}}}; fast_err = 1'b1; end
         OP_MOD:  begin fast_y = {{WIDTH{1'b0}}, bus.a};         fast_err = 1'b1; end
         OP_SHL:  fast_y = {{WIDTH{1'b0}}, shl_w};
         OP_SHR:  fast_y = {{WIDTH{1'b0}}, shr_w};
         OP_RSVD: fast_err = 1'b1;
         default: fast_y = '0;
      endcase
   end

   always_comb begin
      case (sel_r)
         OP_MUL:  slow_y = eng_prod;
         OP_DIV:  slow_y = {{WIDTH{1'b0}}, eng_quot};
         default: slow_y = {{WIDTH{1'b0}}, eng_rem};
      endcase
   end

   always_comb begin
      state_n = state;
      start   = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (long_op && !div0) begin
                  state_n = BUSY;
                  start   = 1'b1;
               end else begin
                  state_n = DONE;
               end
            end
         end
         BUSY:    if (eng_done) state_n = DONE;
         DONE:    if (bus.out_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         sel_r <= 3'b000;
         y_r   <= '0;
         err_r <= 1'b0;
      end else begin
         state <= state_n;
         if (accept)
            sel_r <= bus.sel;
         if (accept && !start) begin
            y_r   <= fast_y;
            err_r <= fast_err;
         end else if (state == BUSY && eng_done) begin
            y_r   <= slow_y;
            err_r <= 1'b0;
         end
      end
   end

   alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .a      (bus.a),
      .b      (bus.b),
      .is_mul (bus.sel == OP_MUL),
      .done   (eng_done),
      .prod   (eng_prod),
      .quot   (eng_quot),
      .rem    (eng_rem)
   );

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq at WIDTH=8
module tb_alu_seq;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_pass;

   alu_seq_if #(.WIDTH(8)) bus ();

   alu_seq #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accept one op, then step until out_valid; optionally pokes in_valid while busy
   task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] opa,
                         input logic [7:0] opb, input int exp_lat, input logic [15:0] exp_y,
                         input logic exp_err, input bit poke);
      int lat;
      check({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.sel      = op;
      bus.a        = opa;
      bus.b        = opb;
      tick();
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 40) begin
         if (poke && lat == 1) begin
            check({tag, "_busy_rdy"}, 32'(bus.in_ready), 32'd0);
            bus.in_valid = 1'b1;
            bus.sel      = 3'b000;
            bus.a        = 8'h01;
            bus.b        = 8'h01;
         end
         tick();
         bus.in_valid = 1'b0;
         lat++;
      end
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check({tag, "_y"}, 32'(bus.y), 32'(exp_y));
      check({tag, "_err"}, 32'(bus.err), 32'(exp_err));
   endtask

   task automatic retire(input string tag);
      tick();
      check({tag, "_drop"}, 32'(bus.out_valid), 32'd0);
      check({tag, "_idle"}, 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      int seen;
      logic [15:0] held;
      n_checks     = 0;
      n_pass       = 0;
      rst_n        = 1'b0;
      bus.in_valid = 1'b1;
      bus.sel      = 3'b000;
      bus.a        = 8'h11;
      bus.b        = 8'h22;
      bus.out_ready = 1'b1;

      repeat (3) tick();
      check("rst_rdy", 32'(bus.in_ready), 32'd0);
      check("rst_ovalid", 32'(bus.out_valid), 32'd0);
      rst_n        = 1'b1;
      bus.in_valid = 1'b0;
      #1;
      check("rel_rdy", 32'(bus.in_ready), 32'd1);
      check("rel_y", 32'(bus.y), 32'd0);
      tick();
      check("rel_ovalid", 32'(bus.out_valid), 32'd0);

      run_op("add", 3'b000, 8'hFF, 8'h01, 1, 16'h0100, 1'b0, 1'b0); retire("add");
      run_op("sub", 3'b001, 8'h05, 8'h0A, 1, 16'h01FB, 1'b0, 1'b0); retire("sub");
      run_op("mul", 3'b010, 8'd200, 8'd200, 9, 16'h9C40, 1'b0, 1'b1); retire("mul");
      tick();
      check("mul_noqueue", 32'(bus.out_valid), 32'd0);
      run_op("div", 3'b011, 8'd200, 8'd7, 9, 16'h001C, 1'b0, 1'b0); retire("div");
      run_op("mod", 3'b100, 8'd200, 8'd7, 9, 16'h0004, 1'b0, 1'b0); retire("mod");
      run_op("div0", 3'b011, 8'h55, 8'h00, 1, 16'h00FF, 1'b1, 1'b0); retire("div0");
      run_op("mod0", 3'b100, 8'h55, 8'h00, 1, 16'h0055, 1'b1, 1'b0); retire("mod0");
      run_op("shl", 3'b101, 8'h81, 8'h0B, 1, 16'h0008, 1'b0, 1'b0); retire("shl");
      run_op("shr", 3'b110, 8'hF0, 8'h04, 1, 16'h000F, 1'b0, 1'b0); retire("shr");
      run_op("rsvd", 3'b111, 8'hAA, 8'h55, 1, 16'h0000, 1'b1, 1'b0); retire("rsvd");

      bus.out_ready = 1'b0;
      run_op("bp", 3'b000, 8'h10, 8'h20, 1, 16'h0030, 1'b0, 1'b0);
      held = bus.y;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_y", 32'(bus.y), 32'(held));
         check("bp_rdy", 32'(bus.in_ready), 32'd0);
         check("bp_ovalid", 32'(bus.out_valid), 32'd1);
      end
      bus.out_ready = 1'b1;
      retire("bp");
      check("bp_hold_idle", 32'(bus.y), 32'h0030);

      bus.in_valid = 1'b1;
      bus.sel      = 3'b010;
      bus.a        = 8'd9;
      bus.b        = 8'd9;
      tick();
      bus.in_valid = 1'b0;
      repeat (4) tick();
      rst_n = 1'b0;
      #1;
      check("abort_ovalid", 32'(bus.out_valid), 32'd0);
      check("abort_y", 32'(bus.y), 32'd0);
      check("abort_rdy", 32'(bus.in_ready), 32'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (bus.out_valid) seen++;
      end
      check("abort_no_pulse", 32'(seen), 32'd0);
      run_op("add2", 3'b000, 8'd3, 8'd4, 1, 16'h0007, 1'b0, 1'b0); retire("add2");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised multi-cycle ALU that replaces the single-cycle 8-bit add/sub ALU. It keeps single-cycle latency for add, sub and shifts, and adds iterative multiply, divide and modulus. Operands enter through a valid/ready handshake, and each result is held until the consumer accepts it. It sits between the operand register stage and the writeback/result stage of the datapath.

## Interface
- WIDTH, 8, operand width in bits (≥4, power of two)
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override)
- clk  in  1  rising-edge clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands and sel are valid
- in_ready  out  1  block can accept an operation
- a  in  WIDTH  operand A (unsigned)
- b  in  WIDTH  operand B (unsigned)
- sel  in  3  operation select
- out_valid  out  1  y and err are valid
- out_ready  in  1  consumer accepts the result
- y  out  2*WIDTH  result
- err  out  1  divide by zero or reserved sel

## Operation
- Opcodes:
  - 000 ADD: y = {carry, a+b}, zero-extended.
  - 001 SUB: y = {borrow, a-b}, zero-extended.
  - 010 MUL: y = full 2*WIDTH product.
  - 011 DIV: y = quotient, zero-extended.
  - 100 MOD: y = remainder, zero-extended.
  - 101 SHL: y = (a << b[SHW-1:0]), truncated to WIDTH, zero-extended.
  - 110 SHR: y = logical a >> b[SHW-1:0], zero-extended.
  - 111 reserved: y = 0, err = 1.
- A transfer occurs when in_valid && in_ready; a, b and sel are captured on that edge.
- FSM states:
  - IDLE: in_ready = 1.
    - Single-cycle ops and reserved sel go to DONE.
    - MUL/DIV/MOD go to BUSY, or straight to DONE if b == 0 for DIV/MOD.
  - BUSY: in_ready = 0.
    - Iteration counter runs WIDTH cycles: shift-add for MUL, restoring divide for DIV/MOD.
    - Goes to DONE when the counter reaches WIDTH-1.
  - DONE: out_valid = 1, and y/err are held stable.
    - When out_ready = 1, goes to IDLE.
- Divide by zero: quotient = all ones (WIDTH bits), remainder = a, err = 1.
- in_valid asserted outside IDLE is ignored; no queuing.
- Reset values: state = IDLE, out_valid = 0, y = 0, err = 0, iteration counter = 0.
  - in_ready = 1 while rst_n is high and state is IDLE.
  - in_ready = 0 while rst_n is low.
- Reset asserted mid-operation aborts immediately. The result is discarded and no out_valid pulse appears.

## Timing
- Latency counts from the accept edge to the first cycle with out_valid high.
  - ADD/SUB/SHL/SHR/reserved/divide-by-zero: 1 cycle.
  - MUL/DIV/MOD: WIDTH+1 cycles.
- y and err are registered outputs. They change only on the edge that enters DONE; they hold their value in IDLE.
- Minimum initiation interval is 2 cycles (DONE→IDLE→accept), even with out_ready tied high. in_ready is not combinationally derived from out_ready.
- out_valid falls on the edge after out_ready is sampled high in DONE.
- Back-pressure: DONE may last any number of cycles; y stays stable throughout.

## Structure
- Package alu_pkg holds:
  - opcode localparams OP_ADD … OP_RSVD;
  - state enum IDLE/BUSY/DONE.
- Sub-module alu_muldiv_iter is the iterative engine.
  - Inputs: start, a, b, is_mul.
  - Outputs: done, prod (2*WIDTH), quot, rem.
  - It owns the iteration counter and partial registers.
- The top module owns the handshake FSM, the single-cycle ops and the result mux.

## Test plan
All scenarios use WIDTH=8.
- Reset and idle: hold rst_n low, then release → in_ready=1, out_valid=0, y=0. Assert in_valid in the cycle rst_n is low → nothing accepted.
- Add carry: ADD a=0xFF, b=0x01 → 1 cycle later y=0x0100, err=0. SUB a=0x05, b=0x0A → y=0x01FB.
- Multiply: MUL a=200, b=200 → out_valid exactly 9 cycles after accept, y=0x9C40. in_ready=0 throughout BUSY, and an in_valid during BUSY is ignored.
- Divide and modulus: DIV 200/7 → y=0x001C; MOD 200/7 → y=0x0004. DIV a=0x55, b=0 → 1 cycle, y=0x00FF, err=1; MOD a=0x55, b=0 → y=0x0055, err=1.
- Shifts, reserved op and back-pressure: SHL a=0x81, b=0x0B → y=0x0008 (b uses low 3 bits = 3). sel=111 → y=0, err=1. Hold out_ready=0 for 5 cycles → y stable and in_ready=0; on release, out_valid drops next cycle.
- Reset mid-MUL: pull rst_n low 4 cycles after accept → out_valid stays 0 and y=0. After release, a new ADD 3+4 → y=0x0007.
